// File: rtl/mult_pkg.sv
// Shared sizing helpers and the per-stage flag bundle for the mult_pipe shift-add multiplier.
package mult_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int calc_nstep(input int w2, input int k);
    return ceil_div(w2, k);
  endfunction

  function automatic int calc_pw(input int w1, input int w2);
    return w1 + w2;
  endfunction

  // Control half of the stage payload; data fields are sized per instance.
  typedef struct packed {
    logic neg;
    logic valid;
  } stage_flags_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// One slice of the shift-add pipeline: adds the partial products of KS multiplier bits
// starting at OFFSET into the accumulator and registers the whole payload when enabled.
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int W1     = 8,
  parameter int W2     = 8,
  parameter int PW     = 16,
  parameter int OFFSET = 0,
  parameter int KS     = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  stage_flags_t   flags_i,
  input  logic [W1-1:0]  mcand_i,
  input  logic [W2-1:0]  mplier_i,
  input  logic [PW-1:0]  acc_i,
  output stage_flags_t   flags_o,
  output logic [W1-1:0]  mcand_o,
  output logic [W2-1:0]  mplier_o,
  output logic [PW-1:0]  acc_o
);

  logic [PW-1:0] acc_d;
  stage_flags_t  flags_q;
  logic [W1-1:0] mcand_q;
  logic [W2-1:0] mplier_q;
  logic [PW-1:0] acc_q;

  always_comb begin
    acc_d = acc_i;
    for (int j = 0; j < KS; j++) begin
      if (mplier_i[OFFSET+j]) begin
        acc_d = acc_d + (PW'(mcand_i) << (OFFSET + j));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (en) begin
      flags_q  <= flags_i;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= acc_d;
    end
  end

  assign flags_o  = flags_q;
  assign mcand_o  = mcand_q;
  assign mplier_o = mplier_q;
  assign acc_o    = acc_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned shift-add multiplier with valid/ready and whole-pipeline stall.
// Define MULT_PIPE_TAG_EN to add an in_tag/out_tag side channel that travels with each operation.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int MULTLEN_1      = 8,
  parameter int MULTLEN_2      = 8,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_W          = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_signed,
  input  logic [MULTLEN_1-1:0]           mult_1,
  input  logic [MULTLEN_2-1:0]           mult_2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MULTLEN_1+MULTLEN_2-1:0] dout
`ifdef MULT_PIPE_TAG_EN
  ,
  input  logic [TAG_W-1:0]               in_tag,
  output logic [TAG_W-1:0]               out_tag
`endif
);

  localparam int W1    = MULTLEN_1;
  localparam int W2    = MULTLEN_2;
  localparam int K     = BITS_PER_STAGE;
  localparam int NSTEP = calc_nstep(W2, K);
  localparam int PW    = calc_pw(W1, W2);

  logic          stall;
  logic          out_valid_q;
  logic [PW-1:0] dout_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Entry: signed operands become magnitudes; -2^(W-1) negates to 2^(W-1), which fits W bits.
  stage_flags_t  entry_flags;
  logic          entry_neg;
  logic [W1-1:0] entry_mcand;
  logic [W2-1:0] entry_mplier;

  assign entry_neg    = in_signed & (mult_1[W1-1] ^ mult_2[W2-1]);
  assign entry_flags  = '{neg: entry_neg, valid: in_valid & in_ready};
  assign entry_mcand  = (in_signed & mult_1[W1-1]) ? -mult_1 : mult_1;
  assign entry_mplier = (in_signed & mult_2[W2-1]) ? -mult_2 : mult_2;

  stage_flags_t  flags_s  [NSTEP];
  logic [W1-1:0] mcand_s  [NSTEP];
  logic [W2-1:0] mplier_s [NSTEP];
  logic [PW-1:0] acc_s    [NSTEP];

  for (genvar gi = 0; gi < NSTEP; gi++) begin : g_stage
    localparam int KS = (gi == NSTEP - 1) ? (W2 - gi * K) : K;

    stage_flags_t  flags_in;
    logic [W1-1:0] mcand_in;
    logic [W2-1:0] mplier_in;
    logic [PW-1:0] acc_in;

    if (gi == 0) begin : g_first
      assign flags_in  = entry_flags;
      assign mcand_in  = entry_mcand;
      assign mplier_in = entry_mplier;
      assign acc_in    = '0;
    end else begin : g_next
      assign flags_in  = flags_s[gi-1];
      assign mcand_in  = mcand_s[gi-1];
      assign mplier_in = mplier_s[gi-1];
      assign acc_in    = acc_s[gi-1];
    end

    mult_pipe_stage #(
      .W1     (W1),
      .W2     (W2),
      .PW     (PW),
      .OFFSET (gi * K),
      .KS     (KS)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (~stall),
      .flags_i  (flags_in),
      .mcand_i  (mcand_in),
      .mplier_i (mplier_in),
      .acc_i    (acc_in),
      .flags_o  (flags_s[gi]),
      .mcand_o  (mcand_s[gi]),
      .mplier_o (mplier_s[gi]),
      .acc_o    (acc_s[gi])
    );
  end

  // Operands are not needed past the final stage.
  logic unused_tail;
  assign unused_tail = ^{mcand_s[NSTEP-1], mplier_s[NSTEP-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (!stall) begin
      out_valid_q <= flags_s[NSTEP-1].valid;
      if (flags_s[NSTEP-1].valid) begin
        dout_q <= flags_s[NSTEP-1].neg ? -acc_s[NSTEP-1] : acc_s[NSTEP-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;

`ifdef MULT_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_q [NSTEP];
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTEP; i++) tag_q[i] <= '0;
      out_tag_q <= '0;
    end else if (!stall) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < NSTEP; i++) tag_q[i] <= tag_q[i-1];
      if (flags_s[NSTEP-1].valid) out_tag_q <= tag_q[NSTEP-1];
    end
  end

  assign out_tag = out_tag_q;
`else
  logic [TAG_W-1:0] unused_tag_w;
  assign unused_tag_w = '0;
`endif

endmodule
